// File: rtl/wb_ahbl_bridge.sv
// Wishbone-classic slave to AHB-lite master bridge. Each Wishbone cycle becomes one
// non-pipelined AHB-lite single transfer. A data-phase stall timeout guarantees an ack.
module wb_ahbl_bridge #(
   parameter logic [7:0]  WB_ADDR_HI   = 8'h30,
   parameter logic [7:0]  AHB_ADDR_HI  = 8'h00,
   parameter int unsigned TIMEOUT      = 256,
   parameter logic [31:0] TIMEOUT_DATA = 32'hBADC0DE5
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [31:0] HRDATA,
   output logic        timeout_flag
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_ACK, S_ACK_DRAIN, S_DRAIN
   } state_t;

   localparam logic [1:0]  TRANS_IDLE   = 2'b00;
   localparam logic [1:0]  TRANS_NONSEQ = 2'b10;
   localparam logic [15:0] CNT_LAST     = 16'(TIMEOUT - 1);

   state_t      state;
   logic [15:0] cnt;
   logic [31:0] wdata_q;
   logic        req;
   logic        sel_legal;
   logic [2:0]  dec_size;
   logic [1:0]  dec_lo;
   logic        unused_adr_lsbs;

   assign req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == WB_ADDR_HI);
   // Byte offset comes from the byte selects, so the address LSBs are ignored.
   assign unused_adr_lsbs = ^wbs_adr_i[1:0];

   always_comb begin
      // NOTE: defaults first, so every path assigns every signal and no latch is inferred.
      sel_legal = 1'b1;
      dec_size  = 3'b010;
      dec_lo    = 2'b00;
      case (wbs_sel_i)
         4'b1111: dec_size = 3'b010;
         4'b0011: dec_size = 3'b001;
         4'b1100: begin dec_size = 3'b001; dec_lo = 2'b10; end
         4'b0001: dec_size = 3'b000;
         4'b0010: begin dec_size = 3'b000; dec_lo = 2'b01; end
         4'b0100: begin dec_size = 3'b000; dec_lo = 2'b10; end
         4'b1000: begin dec_size = 3'b000; dec_lo = 2'b11; end
         default: sel_legal = 1'b0;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state        <= S_IDLE;
         cnt          <= '0;
         wdata_q      <= '0;
         HTRANS       <= TRANS_IDLE;
         HWRITE       <= 1'b0;
         HSIZE        <= 3'b010;
         HADDR        <= {AHB_ADDR_HI, 24'h0};
         HWDATA       <= '0;
         wbs_ack_o    <= 1'b0;
         wbs_dat_o    <= '0;
         timeout_flag <= 1'b0;
      end else begin
         // NOTE: non-blocking updates throughout; every branch reads pre-edge values.
         wbs_ack_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  if (sel_legal) begin
                     HTRANS  <= TRANS_NONSEQ;
                     HADDR   <= {AHB_ADDR_HI, wbs_adr_i[23:2], dec_lo};
                     HSIZE   <= dec_size;
                     HWRITE  <= wbs_we_i;
                     wdata_q <= wbs_dat_i;
                     state   <= S_ADDR;
                  end else begin
                     wbs_dat_o    <= TIMEOUT_DATA;
                     timeout_flag <= 1'b1;
                     wbs_ack_o    <= 1'b1;
                     state        <= S_ACK;
                  end
               end
            end
            S_ADDR: begin
               if (HREADY) begin
                  HTRANS <= TRANS_IDLE;
                  HWDATA <= wdata_q;
                  cnt    <= '0;
                  state  <= S_DATA;
               end
            end
            S_DATA: begin
               if (HREADY) begin
                  wbs_dat_o <= HWRITE ? 32'h0 : HRDATA;
                  wbs_ack_o <= 1'b1;
                  state     <= S_ACK;
               end else if (cnt == CNT_LAST) begin
                  // Ack the Wishbone side now; the stalled AHB transfer is closed in DRAIN.
                  wbs_dat_o    <= TIMEOUT_DATA;
                  timeout_flag <= 1'b1;
                  wbs_ack_o    <= 1'b1;
                  state        <= S_ACK_DRAIN;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_ACK:       state <= S_IDLE;
            S_ACK_DRAIN: state <= S_DRAIN;
            S_DRAIN: begin
               if (HREADY) state <= S_IDLE;
            end
            default:     state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_ahbl_bridge.sv
// Self-checking bench for wb_ahbl_bridge: directed vector table, hand-written timeout,
// drain and async-reset sequences, then random transfers against a behavioural model.
module tb_wb_ahbl_bridge;

   localparam int          T  = 8;
   localparam logic [31:0] TD = 32'hBADC0DE5;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        timeout_flag;

   always #5 HCLK = ~HCLK;

   wb_ahbl_bridge #(
      .WB_ADDR_HI(8'h30), .AHB_ADDR_HI(8'h00), .TIMEOUT(T), .TIMEOUT_DATA(TD)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
      .timeout_flag(timeout_flag)
   );

   // Stimulus plus expected results. ack_cyc counts cycles from the one in which stb is
   // first driven (cycle 0); -1 means no ack is expected.
   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [31:0] rdata;
      int          nwait;
      int          ack_cyc;
      logic [31:0] dat_o;
      int          nonseq;
      logic [31:0] haddr;
      logic [2:0]  hsize;
      logic        flag;
   } vec_t;

   typedef struct {
      int          ack_cyc;
      logic [31:0] dat_o;
      int          nonseq;
      logic [31:0] haddr;
      logic [2:0]  hsize;
      logic        hwrite;
      logic        data_bad;
      logic        ctrl_bad;
      logic        ack_long;
   } res_t;

   int   n_vec = 0;
   int   n_err = 0;
   logic flag_model;

   task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", what, act, exp);
      end
   endtask

   // AHB slave: after an accepted NONSEQ, holds HREADY low for slave_wait data-phase cycles.
   int   slave_wait = 0;
   logic dphase;
   int   wleft;
   initial begin
      HREADY = 1'b1;
      dphase = 1'b0;
      wleft  = 0;
      forever begin
         @(negedge HCLK);
         if (HRESET) begin
            dphase = 1'b0;
            wleft  = 0;
         end else if (HTRANS == 2'b10 && HREADY) begin
            dphase = 1'b1;
            wleft  = slave_wait;
         end else if (dphase && HREADY) begin
            dphase = 1'b0;
         end
         @(posedge HCLK);
         #1;
         if (dphase && wleft > 0) begin
            HREADY = 1'b0;
            wleft--;
         end else begin
            HREADY = 1'b1;
         end
      end
   end

   function automatic vec_t mk(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [31:0] rdata, input int nwait,
                               input int ack, input logic [31:0] dat_o, input int nonseq,
                               input logic [31:0] haddr, input logic [2:0] hsize, input logic flag);
      vec_t v;
      v.we = we; v.sel = sel; v.adr = adr; v.dat = dat; v.rdata = rdata; v.nwait = nwait;
      v.ack_cyc = ack; v.dat_o = dat_o; v.nonseq = nonseq; v.haddr = haddr;
      v.hsize = hsize; v.flag = flag;
      return v;
   endfunction

   // Reference model: a legal sel is a naturally aligned contiguous run of 1, 2 or 4 lanes.
   function automatic vec_t model(input vec_t v);
      vec_t e;
      int   n;
      int   lo;
      logic legal;
      e  = v;
      n  = $countones(v.sel);
      lo = 0;
      for (int i = 3; i >= 0; i--) if (v.sel[i]) lo = i;
      if (n == 1 || n == 2 || n == 4)
         legal = (lo % n == 0) && (v.sel == 4'(((1 << n) - 1) << lo));
      else
         legal = 1'b0;
      e.hsize = (n == 4) ? 3'd2 : (n == 2) ? 3'd1 : 3'd0;
      e.haddr = {8'h00, v.adr[23:2], 2'(lo)};
      e.dat_o = 32'h0;
      if (v.adr[31:24] != 8'h30) begin
         e.ack_cyc = -1;
         e.nonseq  = 0;
      end else if (!legal) begin
         e.ack_cyc  = 1;
         e.nonseq   = 0;
         e.dat_o    = TD;
         flag_model = 1'b1;
      end else if (v.nwait >= T) begin
         e.ack_cyc  = T + 2;
         e.nonseq   = 1;
         e.dat_o    = TD;
         flag_model = 1'b1;
      end else begin
         e.ack_cyc = 3 + v.nwait;
         e.nonseq  = 1;
         e.dat_o   = v.we ? 32'h0 : v.rdata;
      end
      e.flag = flag_model;
      return e;
   endfunction

   // Called at posedge+1; returns at posedge+1 with stb dropped.
   task automatic run_txn(input vec_t v, input int budget, output res_t r);
      logic in_data;
      r.ack_cyc = -1; r.dat_o = '0; r.nonseq = 0; r.haddr = '0; r.hsize = '0;
      r.hwrite = 1'b0; r.data_bad = 1'b0; r.ctrl_bad = 1'b0; r.ack_long = 1'b0;
      in_data    = 1'b0;
      slave_wait = v.nwait;
      HRDATA     = v.rdata;
      wbs_we_i   = v.we;
      wbs_sel_i  = v.sel;
      wbs_adr_i  = v.adr;
      wbs_dat_i  = v.dat;
      wbs_cyc_i  = 1'b1;
      wbs_stb_i  = 1'b1;
      for (int c = 0; c < budget; c++) begin
         @(negedge HCLK);
         if (in_data) begin
            if (HWDATA !== v.dat) r.data_bad = 1'b1;
            if (HTRANS !== 2'b00 || HADDR !== r.haddr || HSIZE !== r.hsize || HWRITE !== r.hwrite)
               r.ctrl_bad = 1'b1;
         end
         if (HTRANS == 2'b10) begin
            if (r.nonseq == 0) begin
               r.haddr  = HADDR;
               r.hsize  = HSIZE;
               r.hwrite = HWRITE;
            end
            r.nonseq++;
         end
         if (in_data && HREADY) in_data = 1'b0;
         if (HTRANS == 2'b10 && HREADY) in_data = 1'b1;
         if (wbs_ack_o && r.ack_cyc < 0) begin
            r.ack_cyc = c;
            r.dat_o   = wbs_dat_o;
         end
         @(posedge HCLK);
         #1;
         if (r.ack_cyc >= 0) break;
      end
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      @(negedge HCLK);
      if (r.ack_cyc >= 0 && wbs_ack_o) r.ack_long = 1'b1;
      @(posedge HCLK);
      #1;
   endtask

   task automatic check_txn(input string nm, input vec_t e, input res_t r);
      check({nm, " ack_cycle"}, 32'(r.ack_cyc), 32'(e.ack_cyc));
      check({nm, " nonseq_cycles"}, 32'(r.nonseq), 32'(e.nonseq));
      check({nm, " timeout_flag"}, {31'b0, timeout_flag}, {31'b0, e.flag});
      if (e.ack_cyc >= 0) begin
         check({nm, " wbs_dat_o"}, r.dat_o, e.dat_o);
         check({nm, " ack_one_cycle"}, {31'b0, r.ack_long}, 32'h0);
      end
      if (e.nonseq > 0) begin
         check({nm, " haddr"}, r.haddr, e.haddr);
         check({nm, " hsize"}, {29'b0, r.hsize}, {29'b0, e.hsize});
         check({nm, " hwrite"}, {31'b0, r.hwrite}, {31'b0, e.we});
         check({nm, " hwdata_in_data"}, {31'b0, r.data_bad}, 32'h0);
         check({nm, " ctrl_stable"}, {31'b0, r.ctrl_bad}, 32'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          dir[8];
      vec_t          v;
      vec_t          e;
      res_t          r;
      logic          saw_ack;
      logic [3:0]    legal_sels[7];

      dir[0] = mk(1'b1, 4'b1111, 32'h3000_0010, 32'hA5A5_1234, 32'h0, 0,
                  3, 32'h0, 1, 32'h0000_0010, 3'b010, 1'b0);
      dir[1] = mk(1'b0, 4'b0100, 32'h3000_0020, 32'h0, 32'hDEAD_BEEF, 0,
                  3, 32'hDEAD_BEEF, 1, 32'h0000_0022, 3'b000, 1'b0);
      dir[2] = mk(1'b0, 4'b1100, 32'h3000_0020, 32'h0, 32'hDEAD_BEEF, 0,
                  3, 32'hDEAD_BEEF, 1, 32'h0000_0022, 3'b001, 1'b0);
      dir[3] = mk(1'b0, 4'b1111, 32'h3000_0104, 32'h0, 32'h1234_5678, 3,
                  6, 32'h1234_5678, 1, 32'h0000_0104, 3'b010, 1'b0);
      dir[4] = mk(1'b1, 4'b0001, 32'h3012_3457, 32'h0000_00C3, 32'hFFFF_FFFF, 1,
                  4, 32'h0, 1, 32'h0012_3454, 3'b000, 1'b0);
      dir[5] = mk(1'b0, 4'b1111, 32'h3100_0000, 32'h0, 32'h0, 0,
                  -1, 32'h0, 0, 32'h0, 3'b000, 1'b0);
      dir[6] = mk(1'b1, 4'b0101, 32'h3000_0040, 32'h0, 32'h0, 0,
                  1, TD, 0, 32'h0, 3'b000, 1'b1);
      dir[7] = mk(1'b0, 4'b0010, 32'h3000_0008, 32'h0, 32'hCAFE_F00D, 0,
                  3, 32'hCAFE_F00D, 1, 32'h0000_0009, 3'b000, 1'b1);

      legal_sels[0] = 4'b1111; legal_sels[1] = 4'b0011; legal_sels[2] = 4'b1100;
      legal_sels[3] = 4'b0001; legal_sels[4] = 4'b0010; legal_sels[5] = 4'b0100;
      legal_sels[6] = 4'b1000;

      HRESET = 1'b1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0; HRDATA = '0;
      flag_model = 1'b0;

      repeat (2) @(posedge HCLK);
      #1;
      check("reset htrans", {30'b0, HTRANS}, 32'h0);
      check("reset hsize", {29'b0, HSIZE}, 32'h2);
      check("reset hwrite", {31'b0, HWRITE}, 32'h0);
      check("reset haddr", HADDR, 32'h0);
      check("reset hwdata", HWDATA, 32'h0);
      check("reset ack", {31'b0, wbs_ack_o}, 32'h0);
      check("reset dat_o", wbs_dat_o, 32'h0);
      check("reset timeout_flag", {31'b0, timeout_flag}, 32'h0);
      @(negedge HCLK);
      HRESET = 1'b0;
      @(posedge HCLK);
      #1;

      for (int i = 0; i < 8; i++) begin
         run_txn(dir[i], 20, r);
         check_txn($sformatf("dir%0d", i), dir[i], r);
      end

      // Timeout: 11 stall cycles; ack after T stall cycles, transfer drained when HREADY rises.
      v = mk(1'b0, 4'b1111, 32'h3000_0300, 32'h0, 32'h5555_AAAA, 11,
             T + 2, TD, 1, 32'h0000_0300, 3'b010, 1'b1);
      run_txn(v, 20, r);
      check_txn("timeout", v, r);
      // Back-to-back request during DRAIN: the drained data phase still has two low cycles,
      // so IDLE returns in cycle 2 and the ack lands in cycle 5 instead of 3.
      v = mk(1'b0, 4'b1111, 32'h3000_0400, 32'h0, 32'h0F1E_2D3C, 0,
             5, 32'h0F1E_2D3C, 1, 32'h0000_0400, 3'b010, 1'b1);
      run_txn(v, 20, r);
      check_txn("after_drain", v, r);

      // Asynchronous reset in the middle of a stalled data phase.
      slave_wait = 5;
      HRDATA     = 32'h0BAD_F00D;
      wbs_we_i   = 1'b0;
      wbs_sel_i  = 4'b1111;
      wbs_adr_i  = 32'h3000_0200;
      wbs_dat_i  = 32'h1111_2222;
      wbs_cyc_i  = 1'b1;
      wbs_stb_i  = 1'b1;
      repeat (3) @(posedge HCLK);
      #3;
      HRESET = 1'b1;
      #1;
      check("midreset htrans", {30'b0, HTRANS}, 32'h0);
      check("midreset hsize", {29'b0, HSIZE}, 32'h2);
      check("midreset haddr", HADDR, 32'h0);
      check("midreset hwdata", HWDATA, 32'h0);
      check("midreset dat_o", wbs_dat_o, 32'h0);
      check("midreset timeout_flag", {31'b0, timeout_flag}, 32'h0);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      @(negedge HCLK);
      #2;
      HRESET = 1'b0;
      saw_ack = 1'b0;
      repeat (6) begin
         @(negedge HCLK);
         if (wbs_ack_o || HTRANS != 2'b00) saw_ack = 1'b1;
      end
      check("midreset no_ack_no_transfer", {31'b0, saw_ack}, 32'h0);
      @(posedge HCLK);
      #1;
      flag_model = 1'b0;
      v = mk(1'b0, 4'b1111, 32'h3000_0500, 32'h0, 32'h7654_3210, 0,
             0, 32'h0, 0, 32'h0, 3'b000, 1'b0);
      e = model(v);
      run_txn(v, 20, r);
      check_txn("post_reset_read", e, r);

      for (int i = 0; i < 60; i++) begin
         v.we    = 1'($urandom);
         v.sel   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : legal_sels[$urandom_range(0, 6)];
         v.adr   = {(($urandom_range(0, 9) == 0) ? 8'h31 : 8'h30), 24'($urandom)};
         v.dat   = $urandom;
         v.rdata = $urandom;
         v.nwait = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T, 11))
                                               : int'($urandom_range(0, 4));
         e = model(v);
         run_txn(v, 20, r);
         check_txn($sformatf("rnd%0d", i), e, r);
         // Let any drained transfer close before the next request.
         if (e.ack_cyc == T + 2) begin
            repeat (4) @(posedge HCLK);
            #1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
